// File: rtl/picorv32_arb_pkg.sv
// Shared types and constants for the two-requester PicoRV32 native-port arbiter.
package picorv32_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_R0   = 2'b01;
    localparam grant_t GRANT_R1   = 2'b10;

endpackage

// File: rtl/picorv32_arb_rr_pick.sv
// Combinational winner selection between two requesters, round-robin or fixed priority.
module picorv32_arb_rr_pick
    import picorv32_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       fixed_prio,
    output grant_t     winner
);

    // On a tie, round-robin hands the port to whoever did not own it last.
    always_comb begin
        winner = GRANT_NONE;
        case (req)
            2'b01:   winner = GRANT_R0;
            2'b10:   winner = GRANT_R1;
            2'b11:   winner = (fixed_prio || last_grant == GRANT_R1) ? GRANT_R0 : GRANT_R1;
            default: winner = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one PicoRV32 native memory port between two requesters, with a
// hung-transfer watchdog that forces completion after TIMEOUT_CYCLES.
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int          PRIORITY_MODE  = PRIO_RR,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        r0_mem_valid,
    input  logic        r0_mem_instr,
    input  logic [31:0] r0_mem_addr,
    input  logic [31:0] r0_mem_wdata,
    input  logic [3:0]  r0_mem_wstrb,
    output logic        r0_mem_ready,
    output logic [31:0] r0_mem_rdata,
    input  logic        r1_mem_valid,
    input  logic        r1_mem_instr,
    input  logic [31:0] r1_mem_addr,
    input  logic [31:0] r1_mem_wdata,
    input  logic [3:0]  r1_mem_wstrb,
    output logic        r1_mem_ready,
    output logic [31:0] r1_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    grant_t           grant_q, grant_d;
    grant_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    grant_t           pick;
    logic             wd_fire;
    logic             in_abort;
    logic             done;

    picorv32_arb_rr_pick u_pick (
        .req        ({r1_mem_valid, r0_mem_valid}),
        .last_grant (last_q),
        .fixed_prio (PRIORITY_MODE == PRIO_FIXED),
        .winner     (pick)
    );

    assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // A completing mem_ready takes precedence over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick != GRANT_NONE) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    grant_d = GRANT_NONE;
                    last_d  = grant_q;
                end else if (wd_fire) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
                last_d  = grant_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_NONE;
            last_q  <= GRANT_R1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_abort  = (state_q == ST_ABORT);
    assign mem_valid = (state_q == ST_BUSY);
    assign done      = (mem_valid && mem_ready) || in_abort;

    assign mem_instr = grant_q[1] ? r1_mem_instr : r0_mem_instr;
    assign mem_addr  = grant_q[1] ? r1_mem_addr  : r0_mem_addr;
    assign mem_wdata = grant_q[1] ? r1_mem_wdata : r0_mem_wdata;
    assign mem_wstrb = grant_q[1] ? r1_mem_wstrb : r0_mem_wstrb;

    assign r0_mem_ready = grant_q[0] && done;
    assign r1_mem_ready = grant_q[1] && done;
    assign r0_mem_rdata = in_abort ? TIMEOUT_RDATA : mem_rdata;
    assign r1_mem_rdata = in_abort ? TIMEOUT_RDATA : mem_rdata;

    assign grant       = grant_q;
    assign timeout_err = in_abort;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: a round-robin/watchdog instance and a
// fixed-priority/no-watchdog instance, each checked every cycle against a transaction model.
module tb_picorv32_mem_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        rv  [2][2];
    logic        ri  [2][2];
    logic [31:0] ra  [2][2];
    logic [31:0] rw  [2][2];
    logic [3:0]  rs  [2][2];
    logic        rrdy[2][2];
    logic [31:0] rrd [2][2];
    logic        mv  [2];
    logic        mi  [2];
    logic [31:0] ma  [2];
    logic [31:0] mw  [2];
    logic [3:0]  ms  [2];
    logic        mrdy[2];
    logic [31:0] mrd [2];
    logic [1:0]  gnt [2];
    logic        tmo [2];

    picorv32_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .resetn(resetn),
        .r0_mem_valid(rv[0][0]), .r0_mem_instr(ri[0][0]), .r0_mem_addr(ra[0][0]),
        .r0_mem_wdata(rw[0][0]), .r0_mem_wstrb(rs[0][0]), .r0_mem_ready(rrdy[0][0]),
        .r0_mem_rdata(rrd[0][0]),
        .r1_mem_valid(rv[0][1]), .r1_mem_instr(ri[0][1]), .r1_mem_addr(ra[0][1]),
        .r1_mem_wdata(rw[0][1]), .r1_mem_wstrb(rs[0][1]), .r1_mem_ready(rrdy[0][1]),
        .r1_mem_rdata(rrd[0][1]),
        .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_addr(ma[0]), .mem_wdata(mw[0]),
        .mem_wstrb(ms[0]), .mem_ready(mrdy[0]), .mem_rdata(mrd[0]),
        .grant(gnt[0]), .timeout_err(tmo[0])
    );

    picorv32_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) dut_fx (
        .clk(clk), .resetn(resetn),
        .r0_mem_valid(rv[1][0]), .r0_mem_instr(ri[1][0]), .r0_mem_addr(ra[1][0]),
        .r0_mem_wdata(rw[1][0]), .r0_mem_wstrb(rs[1][0]), .r0_mem_ready(rrdy[1][0]),
        .r0_mem_rdata(rrd[1][0]),
        .r1_mem_valid(rv[1][1]), .r1_mem_instr(ri[1][1]), .r1_mem_addr(ra[1][1]),
        .r1_mem_wdata(rw[1][1]), .r1_mem_wstrb(rs[1][1]), .r1_mem_ready(rrdy[1][1]),
        .r1_mem_rdata(rrd[1][1]),
        .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_addr(ma[1]), .mem_wdata(mw[1]),
        .mem_wstrb(ms[1]), .mem_ready(mrdy[1]), .mem_rdata(mrd[1]),
        .grant(gnt[1]), .timeout_err(tmo[1])
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int rdy_cnt[2][2];
    int tmo_cnt[2];

    // Transaction model: who owns the port, how many stalled cycles it has had, abort flag.
    int m_owner[2];
    int m_age[2];
    int m_last[2];
    bit m_abort[2];

    function automatic int modeOf(int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int limitOf(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic checkOutput(string name, int d, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < 2; d++) begin
                m_owner[d] = -1;
                m_age[d]   = 0;
                m_abort[d] = 1'b0;
                m_last[d]  = 1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_owner[d] < 0) begin
                    if (rv[d][0] && rv[d][1])
                        m_owner[d] = (modeOf(d) == 1) ? 0 : 1 - m_last[d];
                    else if (rv[d][0])
                        m_owner[d] = 0;
                    else if (rv[d][1])
                        m_owner[d] = 1;
                    m_age[d]   = 0;
                    m_abort[d] = 1'b0;
                end else if (m_abort[d]) begin
                    m_last[d]  = m_owner[d];
                    m_owner[d] = -1;
                    m_abort[d] = 1'b0;
                end else if (mrdy[d]) begin
                    m_last[d]  = m_owner[d];
                    m_owner[d] = -1;
                end else if (limitOf(d) > 0 && m_age[d] == limitOf(d) - 1) begin
                    m_abort[d] = 1'b1;
                end else begin
                    m_age[d] = m_age[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int o;
                bit busy;
                bit er;
                o    = m_owner[d];
                busy = (o >= 0) && !m_abort[d];
                checkOutput("mem_valid", d, 32'(mv[d]), 32'(busy));
                checkOutput("grant", d, 32'(gnt[d]), (o < 0) ? 32'd0 : 32'(1 << o));
                checkOutput("timeout_err", d, 32'(tmo[d]), 32'((o >= 0) && m_abort[d]));
                for (int k = 0; k < 2; k++) begin
                    er = (o == k) && (m_abort[d] || (busy && mrdy[d]));
                    checkOutput("ready", d, 32'(rrdy[d][k]), 32'(er));
                    if (er)
                        checkOutput("rdata", d, rrd[d][k], m_abort[d] ? 32'hDEAD_BEEF : mrd[d]);
                    if (rrdy[d][k])
                        rdy_cnt[d][k]++;
                end
                if (busy) begin
                    checkOutput("mem_addr", d, ma[d], ra[d][o]);
                    checkOutput("mem_wdata", d, mw[d], rw[d][o]);
                    checkOutput("mem_wstrb", d, 32'(ms[d]), 32'(rs[d][o]));
                    checkOutput("mem_instr", d, 32'(mi[d]), 32'(ri[d][o]));
                end
                if (tmo[d])
                    tmo_cnt[d]++;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(int d);
        int n;
        n = 0;
        while (!mv[d] && n < 20) begin
            tick();
            n++;
        end
        if (!mv[d])
            checkOutput("wait_valid", d, 32'(mv[d]), 32'd1);
    endtask

    task automatic applyStimulus();
        int b0;
        int b1;
        int n;
        logic [1:0] seq[4];
        logic [1:0] exp_seq[4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Single r0 read, response two cycles after mem_valid.
        ra[0][0] = 32'h0000_1000; rs[0][0] = 4'b0000; ri[0][0] = 1'b1; rv[0][0] = 1'b1;
        b0 = rdy_cnt[0][0]; b1 = rdy_cnt[0][1];
        waitValid(0);
        checkOutput("t1_grant", 0, 32'(gnt[0]), 32'h1);
        tick(2);
        mrd[0] = 32'h1234_5678; mrdy[0] = 1'b1;
        #1;
        checkOutput("t1_ready", 0, 32'(rrdy[0][0]), 32'h1);
        checkOutput("t1_rdata", 0, rrd[0][0], 32'h1234_5678);
        tick();
        mrdy[0] = 1'b0; rv[0][0] = 1'b0;
        tick(2);
        checkOutput("t1_r0_pulses", 0, 32'(rdy_cnt[0][0] - b0), 32'd1);
        checkOutput("t1_r1_pulses", 0, 32'(rdy_cnt[0][1] - b1), 32'd0);

        // r1 write must pass through untouched for every BUSY cycle.
        ra[0][1] = 32'h2000_0004; rw[0][1] = 32'hAABB_CCDD; rs[0][1] = 4'b0011;
        ri[0][1] = 1'b0; rv[0][1] = 1'b1;
        waitValid(0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_addr", 0, ma[0], 32'h2000_0004);
            checkOutput("t2_wdata", 0, mw[0], 32'hAABB_CCDD);
            checkOutput("t2_wstrb", 0, 32'(ms[0]), 32'h3);
            checkOutput("t2_grant", 0, 32'(gnt[0]), 32'h2);
            if (i < 2) tick();
        end
        mrdy[0] = 1'b1;
        #1;
        checkOutput("t2_ready", 0, 32'(rrdy[0][1]), 32'h1);
        tick();
        mrdy[0] = 1'b0; rv[0][1] = 1'b0;
        tick();

        // Round-robin contention with both requesters held valid.
        ra[0][0] = 32'h0000_0100; ra[0][1] = 32'h0000_0200;
        rv[0][0] = 1'b1; rv[0][1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitValid(0);
            seq[i] = gnt[0];
            tick();
            mrd[0] = 32'(i); mrdy[0] = 1'b1;
            tick();
            mrdy[0] = 1'b0;
            checkOutput("t3_idle_gap", 0, 32'(mv[0]), 32'h0);
        end
        rv[0][0] = 1'b0; rv[0][1] = 1'b0;
        for (int i = 0; i < 4; i++)
            checkOutput("t3_grant_seq", 0, 32'(seq[i]), 32'(exp_seq[i]));
        tick();

        // Watchdog abort after four unanswered BUSY cycles.
        ra[0][0] = 32'h0000_3000; rv[0][0] = 1'b1;
        b0 = tmo_cnt[0];
        waitValid(0);
        n = 0;
        while (mv[0] && n < 20) begin
            n++;
            tick();
        end
        checkOutput("t4_busy_cycles", 0, 32'(n), 32'd4);
        checkOutput("t4_ready", 0, 32'(rrdy[0][0]), 32'h1);
        checkOutput("t4_rdata", 0, rrd[0][0], 32'hDEAD_BEEF);
        checkOutput("t4_timeout_err", 0, 32'(tmo[0]), 32'h1);
        rv[0][0] = 1'b0;
        tick();
        mrdy[0] = 1'b1;
        #1;
        checkOutput("t4_stray_r0", 0, 32'(rrdy[0][0]), 32'h0);
        checkOutput("t4_stray_r1", 0, 32'(rrdy[0][1]), 32'h0);
        tick();
        mrdy[0] = 1'b0;
        checkOutput("t4_err_pulses", 0, 32'(tmo_cnt[0] - b0), 32'd1);

        // mem_ready in the last allowed cycle wins; r1 also drops valid early.
        rv[0][1] = 1'b1;
        waitValid(0);
        tick(3);
        rv[0][1] = 1'b0; mrdy[0] = 1'b1; mrd[0] = 32'h0BAD_F00D;
        #1;
        checkOutput("t5_ready", 0, 32'(rrdy[0][1]), 32'h1);
        checkOutput("t5_no_abort", 0, 32'(tmo[0]), 32'h0);
        tick();
        mrdy[0] = 1'b0;
        checkOutput("t5_idle_no_err", 0, 32'(tmo[0]), 32'h0);
        tick();

        // Fixed priority keeps r0 winning while it stays valid.
        ra[1][0] = 32'h0000_4000; ra[1][1] = 32'h0000_5000;
        rv[1][0] = 1'b1; rv[1][1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitValid(1);
            checkOutput("t6_grant_r0", 1, 32'(gnt[1]), 32'h1);
            tick();
            mrdy[1] = 1'b1;
            tick();
            mrdy[1] = 1'b0;
            if (i == 2) rv[1][0] = 1'b0;
        end
        waitValid(1);
        checkOutput("t6_grant_r1", 1, 32'(gnt[1]), 32'h2);
        tick(300);
        checkOutput("t6_no_watchdog", 1, 32'(mv[1]), 32'h1);
        mrdy[1] = 1'b1;
        tick();
        mrdy[1] = 1'b0; rv[1][1] = 1'b0;
        tick();

        // Asynchronous reset in the middle of a transfer.
        rv[0][0] = 1'b1;
        waitValid(0);
        rv[0][1] = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t7_rst_valid", 0, 32'(mv[0]), 32'h0);
        checkOutput("t7_rst_grant", 0, 32'(gnt[0]), 32'h0);
        checkOutput("t7_rst_ready", 0, 32'(rrdy[0][0]), 32'h0);
        #10;
        resetn = 1'b1;
        tick();
        checkOutput("t7_first_tie", 0, 32'(gnt[0]), 32'h1);
        mrdy[0] = 1'b1;
        tick();
        mrdy[0] = 1'b0; rv[0][0] = 1'b0; rv[0][1] = 1'b0;
        tick(2);
    endtask

    initial begin
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mrdy[d] = 1'b0;
            mrd[d]  = 32'h0;
            tmo_cnt[d] = 0;
            for (int k = 0; k < 2; k++) begin
                rv[d][k] = 1'b0; ri[d][k] = 1'b0; ra[d][k] = 32'h0;
                rw[d][k] = 32'h0; rs[d][k] = 4'h0; rdy_cnt[d][k] = 0;
            end
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_valid", d, 32'(mv[d]), 32'h0);
            checkOutput("reset_grant", d, 32'(gnt[d]), 32'h0);
            checkOutput("reset_ready0", d, 32'(rrdy[d][0]), 32'h0);
            checkOutput("reset_ready1", d, 32'(rrdy[d][1]), 32'h0);
            checkOutput("reset_timeout", d, 32'(tmo[d]), 32'h0);
        end
        resetn = 1'b1;
        tick();
        chk_en = 1'b1;
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
